// File: rtl/zeroheti_obi_arb.sv
// zeroheti_obi_arb: round-robin OBI arbiter with locked selection and in-order response routing
module zeroheti_obi_arb #(
  parameter int NumMgr    = 3,
  parameter int MaxTrans  = 2,
  parameter int DataWidth = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumMgr-1:0]                     mgr_req_i,
  input  logic [NumMgr-1:0][31:0]               mgr_addr_i,
  input  logic [NumMgr-1:0]                     mgr_we_i,
  input  logic [NumMgr-1:0][DataWidth/8-1:0]    mgr_be_i,
  input  logic [NumMgr-1:0][DataWidth-1:0]      mgr_wdata_i,
  output logic [NumMgr-1:0]                     mgr_gnt_o,
  output logic [NumMgr-1:0]                     mgr_rvalid_o,
  output logic [DataWidth-1:0]                  mgr_rdata_o,
  output logic                                  mgr_err_o,
  output logic                                  sbr_req_o,
  output logic [31:0]                           sbr_addr_o,
  output logic                                  sbr_we_o,
  output logic [DataWidth/8-1:0]                sbr_be_o,
  output logic [DataWidth-1:0]                  sbr_wdata_o,
  input  logic                                  sbr_gnt_i,
  input  logic                                  sbr_rvalid_i,
  input  logic [DataWidth-1:0]                  sbr_rdata_i,
  input  logic                                  sbr_err_i,
  output logic                                  busy_o
);
  localparam int IW = NumMgr > 1 ? $clog2(NumMgr) : 1;
  localparam int PW = MaxTrans > 1 ? $clog2(MaxTrans) : 1;
  localparam int CW = $clog2(MaxTrans + 1);

  logic [IW-1:0] rr_q, lock_idx_q, rr_pick, sel, head;
  logic          lock_q, rr_any, sel_valid, hs, pop;
  logic [IW-1:0] ids_q [MaxTrans];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  // Round-robin candidate: lowest offset after rr_q wins, so scan offsets downwards
  always_comb begin
    rr_pick = '0;
    rr_any  = 1'b0;
    for (int i = NumMgr; i >= 1; i--) begin
      if (mgr_req_i[IW'((int'(rr_q) + i) % NumMgr)]) begin
        rr_pick = IW'((int'(rr_q) + i) % NumMgr);
        rr_any  = 1'b1;
      end
    end
  end

  // Selection holds on the locked manager until its request is accepted
  always_comb begin
    sel          = lock_q ? lock_idx_q : rr_pick;
    sel_valid    = lock_q ? mgr_req_i[lock_idx_q] : rr_any;
    sbr_req_o    = rst_ni && sel_valid && (cnt_q < CW'(MaxTrans));
    sbr_addr_o   = mgr_addr_i[sel];
    sbr_we_o     = mgr_we_i[sel];
    sbr_be_o     = mgr_be_i[sel];
    sbr_wdata_o  = mgr_wdata_i[sel];
    hs           = sbr_req_o && sbr_gnt_i;
    mgr_gnt_o    = hs ? NumMgr'(1) << sel : '0;
    pop          = sbr_rvalid_i && (cnt_q != '0);
    head         = ids_q[rptr_q];
    mgr_rvalid_o = pop ? NumMgr'(1) << head : '0;
    mgr_rdata_o  = sbr_rdata_i;
    mgr_err_o    = sbr_err_i;
    busy_o       = cnt_q != '0;
  end

  // Arbitration pointer, lock and ID FIFO bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= IW'(NumMgr - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      lock_q     <= sbr_req_o && !sbr_gnt_i;
      lock_idx_q <= sel;
      cnt_q      <= cnt_q + CW'(hs) - CW'(pop);
      if (hs) begin
        rr_q   <= sel;
        wptr_q <= wptr_q == PW'(MaxTrans - 1) ? '0 : wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q == PW'(MaxTrans - 1) ? '0 : rptr_q + 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read once counted as valid
  always_ff @(posedge clk_i) begin
    if (hs) ids_q[wptr_q] <= sel;
  end
endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// tb_zeroheti_obi_arb: directed checks of arbitration, locking, FIFO routing and reset
module tb_zeroheti_obi_arb;
  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [2:0]        mgr_req_i;
  logic [2:0][31:0]  mgr_addr_i;
  logic [2:0]        mgr_we_i;
  logic [2:0][3:0]   mgr_be_i;
  logic [2:0][31:0]  mgr_wdata_i;
  logic [2:0]        mgr_gnt_o, mgr_rvalid_o;
  logic [31:0]       mgr_rdata_o;
  logic              mgr_err_o;
  logic              sbr_req_o;
  logic [31:0]       sbr_addr_o;
  logic              sbr_we_o;
  logic [3:0]        sbr_be_o;
  logic [31:0]       sbr_wdata_o;
  logic              sbr_gnt_i, sbr_rvalid_i, sbr_err_i;
  logic [31:0]       sbr_rdata_i;
  logic              busy_o;
  int                checks = 0;
  int                errors = 0;

  zeroheti_obi_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
    .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o),
    .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
    .sbr_req_o(sbr_req_o), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
    .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i),
    .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic gnt, input logic rv, input logic err);
    mgr_req_i    = req;
    sbr_gnt_i    = gnt;
    sbr_rvalid_i = rv;
    sbr_err_i    = err;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    mgr_addr_i  = {32'hA000_0020, 32'hA000_0010, 32'hA000_0000};
    mgr_we_i    = 3'b010;
    mgr_be_i    = {4'hC, 4'h3, 4'hF};
    mgr_wdata_i = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    sbr_rdata_i = 32'h0;
    drive(3'b111, 1'b1, 1'b1, 1'b0);
    #12;
    chk("rst_req", sbr_req_o, 0);
    chk("rst_gnt", mgr_gnt_o, 0);
    chk("rst_rvalid", mgr_rvalid_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // continuous requests from all three managers, response one cycle later
    drive(3'b111, 1'b1, 1'b0, 1'b0);
    chk("rr_g0", mgr_gnt_o, 3'b001);
    chk("rr_addr0", sbr_addr_o, 32'hA000_0000);
    tick();
    sbr_rdata_i = 32'hDEAD_0001;
    drive(3'b111, 1'b1, 1'b1, 1'b0);
    chk("rr_g1", mgr_gnt_o, 3'b010);
    chk("rr_fields1", {sbr_we_o, sbr_be_o, sbr_wdata_o}, {1'b1, 4'h3, 32'h1111_1111});
    chk("rr_rv0", mgr_rvalid_o, 3'b001);
    chk("rr_rdata", mgr_rdata_o, 32'hDEAD_0001);
    tick();
    chk("rr_g2", mgr_gnt_o, 3'b100);
    chk("rr_rv1", mgr_rvalid_o, 3'b010);
    chk("rr_busy", busy_o, 1);
    tick();
    chk("rr_g3", mgr_gnt_o, 3'b001);
    chk("rr_rv2", mgr_rvalid_o, 3'b100);
    tick();
    chk("rr_g4", mgr_gnt_o, 3'b010);
    chk("rr_rv3", mgr_rvalid_o, 3'b001);
    tick();
    chk("rr_g5", mgr_gnt_o, 3'b100);
    chk("rr_rv4", mgr_rvalid_o, 3'b010);
    tick();
    drive(3'b000, 1'b1, 1'b1, 1'b0);
    chk("rr_rv5", mgr_rvalid_o, 3'b100);
    chk("rr_nogrant", mgr_gnt_o, 3'b000);
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    chk("rr_idle", busy_o, 0);

    // manager 1 held off, manager 0 arrives later and must not preempt
    drive(3'b010, 1'b0, 1'b0, 1'b0);
    chk("lk_req1", sbr_req_o, 1);
    chk("lk_addr1", sbr_addr_o, 32'hA000_0010);
    tick();
    drive(3'b011, 1'b0, 1'b0, 1'b0);
    chk("lk_addr2", sbr_addr_o, 32'hA000_0010);
    chk("lk_gnt2", mgr_gnt_o, 3'b000);
    tick();
    chk("lk_addr3", sbr_addr_o, 32'hA000_0010);
    tick();
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    chk("lk_gnt4", mgr_gnt_o, 3'b010);
    chk("lk_addr4", sbr_addr_o, 32'hA000_0010);
    tick();

    // fill to MaxTrans, then one response reopens the request path
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    chk("mt_gnt0", mgr_gnt_o, 3'b001);
    tick();
    chk("mt_full_req", sbr_req_o, 0);
    chk("mt_full_gnt", mgr_gnt_o, 3'b000);
    chk("mt_full_busy", busy_o, 1);
    tick();
    drive(3'b001, 1'b1, 1'b1, 1'b0);
    chk("mt_nobypass", sbr_req_o, 0);
    chk("mt_rv1", mgr_rvalid_o, 3'b010);
    tick();
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    chk("mt_reopen", mgr_gnt_o, 3'b001);
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    chk("mt_drain0", mgr_rvalid_o, 3'b001);
    tick();
    chk("mt_drain1", mgr_rvalid_o, 3'b001);
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    chk("mt_idle", busy_o, 0);

    // responses for IDs 2 then 0, error only on the second
    drive(3'b100, 1'b1, 1'b0, 1'b0);
    chk("io_g2", mgr_gnt_o, 3'b100);
    tick();
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    chk("io_g0", mgr_gnt_o, 3'b001);
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    chk("io_rv2", {mgr_rvalid_o, mgr_err_o}, {3'b100, 1'b0});
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b1);
    chk("io_rv0", {mgr_rvalid_o, mgr_err_o}, {3'b001, 1'b1});
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    chk("io_idle", busy_o, 0);

    // push and pop together at count 1
    drive(3'b010, 1'b1, 1'b0, 1'b0);
    chk("pp_g1", mgr_gnt_o, 3'b010);
    tick();
    drive(3'b100, 1'b1, 1'b1, 1'b0);
    chk("pp_g2", mgr_gnt_o, 3'b100);
    chk("pp_rv1", mgr_rvalid_o, 3'b010);
    tick();
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    chk("pp_cnt1", {sbr_req_o, busy_o, mgr_gnt_o}, {1'b1, 1'b1, 3'b001});
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    chk("pp_rv2", mgr_rvalid_o, 3'b100);
    tick();
    chk("pp_rv0", mgr_rvalid_o, 3'b001);
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    chk("pp_drop", mgr_rvalid_o, 3'b000);
    tick();
    chk("pp_idle", busy_o, 0);

    // reset with a transaction outstanding, then a stale response
    drive(3'b010, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rs_busy_pre", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rs_busy_async", busy_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    chk("rs_spurious", mgr_rvalid_o, 3'b000);
    tick();
    drive(3'b011, 1'b0, 1'b0, 1'b0);
    chk("rs_cnt0", busy_o, 0);
    chk("rs_rr_reset", sbr_addr_o, 32'hA000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/zeroheti_obi_arb.md
ZEROHETI_OBI_ARB -- requirements
Module: zeroheti_obi_arb

Interface
REQ-001 SHALL have parameter NumMgr, default 3, number of OBI managers sharing one subordinate (index 0 = cpu_if, 1 = cpu_lsu, 2 = sba).
REQ-002 SHALL have parameter MaxTrans, default 2, maximum outstanding accepted transactions (1..8).
REQ-003 SHALL have parameter DataWidth, default 32; address width is fixed at 32; byte-enable width is DataWidth/8.
REQ-004 Ports:
- clk_i, input, 1, sole clock.
- rst_ni, input, 1, reset, asynchronous, active-low.
- mgr_req_i, input, NumMgr, per-manager request.
- mgr_addr_i, input, NumMgr x 32, address.
- mgr_we_i, input, NumMgr, write enable.
- mgr_be_i, input, NumMgr x DataWidth/8, byte enables.
- mgr_wdata_i, input, NumMgr x DataWidth, write data.
- mgr_gnt_o, output, NumMgr, per-manager grant.
- mgr_rvalid_o, output, NumMgr, response valid.
- mgr_rdata_o, output, DataWidth, read data, broadcast to all managers.
- mgr_err_o, output, 1, response error, broadcast to all managers.
- sbr_req_o, output, 1, request to the subordinate.
- sbr_addr_o / sbr_we_o / sbr_be_o / sbr_wdata_o, output, muxed request fields.
- sbr_gnt_i, input, 1, subordinate grant.
- sbr_rvalid_i, input, 1, subordinate response valid.
- sbr_rdata_i, input, DataWidth, subordinate read data.
- sbr_err_i, input, 1, subordinate response error.
- busy_o, output, 1, high when any transaction is outstanding.

Function
REQ-005 Round-robin arbitration: winner is the first requesting index strictly after last-granted pointer rr_q, wrapping NumMgr-1 -> 0; rr_q resets to NumMgr-1, so index 0 wins first.
REQ-006 Lock: once sbr_req_o is asserted for manager k without a handshake, selection SHALL stay on k until the sbr_req_o && sbr_gnt_i handshake; new higher-ranked requests do not preempt.
REQ-007 sbr_req_o = (any selected request) && (outstanding count < MaxTrans); request fields SHALL be a combinational mux of the selected manager.
REQ-008 mgr_gnt_o[k] = sbr_gnt_i && sbr_req_o && (k == selected); at most one bit is set; zero-cycle combinational path from sbr_gnt_i.
REQ-009 On handshake: push k into an ID FIFO of depth MaxTrans, set rr_q <= k, and release the lock.
REQ-010 On sbr_rvalid_i: pop the FIFO head h; mgr_rvalid_o[h] = 1 in the same cycle; rdata and err pass through combinationally.
REQ-011 Same-cycle push and pop SHALL leave the count unchanged and order preserved; a full FIFO with a pop in the same cycle SHALL NOT admit a new request that cycle (no full-bypass).
REQ-012 sbr_rvalid_i with an empty FIFO SHALL be dropped: no mgr_rvalid_o, no pointer change.
REQ-013 Count SHALL be held in ceil(log2(MaxTrans+1)) bits and SHALL never exceed MaxTrans; FIFO read and write pointers wrap modulo MaxTrans.
REQ-014 busy_o = (count != 0), registered.

Reset
REQ-015 While rst_ni is low, all state (FIFO pointers, count, rr_q, lock) SHALL reset asynchronously; sbr_req_o, mgr_gnt_o, mgr_rvalid_o and busy_o read 0.
REQ-016 Reset asserted mid-transaction SHALL discard outstanding IDs; after release, responses from the prior transaction are dropped per REQ-012.

Verification
REQ-017 Bench SHALL cover the following:
- Managers 0, 1 and 2 requesting continuously, sbr_gnt_i=1, immediate rvalid -> grant order 0,1,2,0,1,2.
- Manager 1 requesting, sbr_gnt_i=0 for 3 cycles, manager 0 raises its request in cycle 2 -> sbr_req_o stays on manager 1 with stable address; gnt[1] on cycle 4.
- MaxTrans=2, no rvalid -> two handshakes, then sbr_req_o=0 with busy_o=1; one rvalid re-enables it the next cycle.
- Responses return in order for IDs 2,0 -> mgr_rvalid_o[2] then mgr_rvalid_o[0]; err=1 on the second response appears only with mgr_rvalid_o[0].
- Push and pop in the same cycle at count=1 -> count stays 1 and FIFO order is preserved.
- Spurious rvalid after mid-transaction reset -> no mgr_rvalid_o and count stays 0.
